morse_serializer: RTL

Downstream stage of the ASCII-to-Morse translator. Accepts one 22-bit Morse pattern per handshake and plays it out LSB-first on a single keyed line, with one bit per Morse unit: bit=1 means tone on, bit=0 means tone off. It then appends the inter-character gap, or emits a word gap for an all-zero (space) pattern. The keyed line drives the transmitter LED/buzzer output stage.

---
 rtl/morse_pkg.sv | 12 +
 rtl/morse_serializer_if.sv | 9 +
 rtl/morse_unit_tick.sv | 23 ++
 rtl/morse_serializer.sv | 119 +++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared constants and state type for the Morse serializer.
package morse_pkg;
  localparam int MORSE_W        = 22;
  localparam int CHAR_GAP_UNITS = 3;
  localparam int WORD_GAP_UNITS = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } morse_st_t;
endpackage

// File: rtl/morse_serializer_if.sv
// Valid/ready pattern handshake between the translator and the serializer.
interface morse_serializer_if;
  logic                         sym_valid;
  logic                         sym_ready;
  logic [morse_pkg::MORSE_W-1:0] sym_data;

  modport master (output sym_valid, output sym_data, input sym_ready);
  modport slave  (input sym_valid, input sym_data, output sym_ready);
endinterface

// File: rtl/morse_unit_tick.sv
// Unit prescaler: counts 0..UNIT_CYCLES-1 while run is high, tick on the last cycle.
module morse_unit_tick #(
  parameter int UNIT_CYCLES = 12_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);
  localparam int CW = $clog2(UNIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(UNIT_CYCLES - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt_reg <= '0;
    else if (!run)           cnt_reg <= '0;
    else if (cnt_reg == LAST) cnt_reg <= '0;
    else                     cnt_reg <= cnt_reg + 1'b1;
  end

  assign tick = run && (cnt_reg == LAST);
endmodule

// File: rtl/morse_serializer.sv
// Plays a 22-bit Morse pattern LSB-first on the keyed tone line, then the gap.
// Optional buzzer square-wave output: define MORSE_SERIALIZER_BUZZER_EN.
module morse_serializer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12_000_000,
  parameter int BUZZ_HALF   = 12_500
) (
  input  logic                     clk,
  input  logic                     rst_n,
  morse_serializer_if.slave        sym,
  output logic                     tone,
  output logic                     busy
`ifdef MORSE_SERIALIZER_BUZZER_EN
  ,
  output logic                     buzz
`endif
);
  morse_st_t            state_reg, state_next;
  logic [MORSE_W-1:0]   sreg_reg, sreg_next;
  logic [2:0]           gcnt_reg, gcnt_next;
  logic                 tone_reg, tone_next;
  logic                 busy_reg, ready_reg;
  logic                 tick;

  morse_unit_tick #(.UNIT_CYCLES(UNIT_CYCLES)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (state_reg != IDLE),
    .tick (tick)
  );

  always_comb begin
    state_next = state_reg;
    sreg_next  = sreg_reg;
    gcnt_next  = gcnt_reg;
    case (state_reg)
      IDLE: begin
        if (sym.sym_valid) begin
          if (sym.sym_data != '0) begin
            sreg_next  = sym.sym_data;
            state_next = SEND;
          end else begin
            gcnt_next  = 3'(WORD_GAP_UNITS);
            state_next = GAP;
          end
        end
      end
      SEND: begin
        if (tick) begin
          sreg_next = sreg_reg >> 1;
          if ((sreg_reg >> 1) == '0) begin
            gcnt_next  = 3'(CHAR_GAP_UNITS);
            state_next = GAP;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gcnt_reg == 3'd1) state_next = IDLE;
          else                  gcnt_next  = gcnt_reg - 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    // tone is registered from the next state so it is valid from the accepting edge
    tone_next = (state_next == SEND) && sreg_next[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sreg_reg  <= '0;
      gcnt_reg  <= '0;
      tone_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      ready_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      sreg_reg  <= sreg_next;
      gcnt_reg  <= gcnt_next;
      tone_reg  <= tone_next;
      busy_reg  <= (state_next != IDLE);
      ready_reg <= (state_next == IDLE);
    end
  end

  assign tone          = tone_reg;
  assign busy          = busy_reg;
  assign sym.sym_ready = ready_reg;

`ifdef MORSE_SERIALIZER_BUZZER_EN
  localparam int BW = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;
  localparam logic [BW-1:0] BLAST = BW'(BUZZ_HALF - 1);

  logic [BW-1:0] bcnt_reg;
  logic          buzz_reg;

  // Counting starts once tone is high, so the first toggle lands BUZZ_HALF cycles after the rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_reg <= '0;
      buzz_reg <= 1'b0;
    end else if (!tone_next) begin
      bcnt_reg <= '0;
      buzz_reg <= 1'b0;
    end else if (tone_reg) begin
      if (bcnt_reg == BLAST) begin
        bcnt_reg <= '0;
        buzz_reg <= ~buzz_reg;
      end else begin
        bcnt_reg <= bcnt_reg + 1'b1;
      end
    end
  end

  assign buzz = buzz_reg;
`endif
endmodule
